mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the RAM access cycles per transfer; legal range 1..15.
REQ-002 Clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  in  1  SHALL be asynchronous, active-high.
REQ-004 FetchReq  in  1  SHALL be the instruction-fetch read request, held until FetchAck.
REQ-005 FetchAddr  in  32  SHALL be the fetch address, stable while FetchReq=1.
REQ-006 FetchAck  out  1  SHALL be a one-cycle fetch completion pulse.
REQ-007 FetchData  out  32  SHALL carry the read word, valid in the FetchAck cycle.
REQ-008 DataReq  in  1  SHALL be the LDR/STR request from the memory controller, held until DataAck.
REQ-009 DataRW  in  1  SHALL select the data access type: 0=read (LDR), 1=write (STR).
REQ-010 DataAddr  in  32  SHALL be the data address, stable while DataReq=1.
REQ-011 DataWdata  in  32  SHALL be the store data, stable while DataReq=1.
REQ-012 DataAck  out  1  SHALL be a one-cycle data completion pulse.
REQ-013 DataRdata  out  32  SHALL carry the LDR word, valid in the DataAck cycle.
REQ-014 AddressBus  out  32  SHALL be the RAM address.
REQ-015 Dout  out  32  SHALL be the RAM write data.
REQ-016 RW  out  1  SHALL be the RAM direction: 1=write, 0=read.
REQ-017 BusEn  out  1  SHALL qualify AddressBus/Dout/RW as a valid access.
REQ-018 Din  in  32  SHALL be the RAM read data.
REQ-019 Busy  out  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL use the states IDLE, ACCESS and RESP.
REQ-021 IDLE SHALL move to ACCESS on the rising edge at which FetchReq or DataReq is 1, latching the winner, address, RW and write data.
REQ-022 When both requests are pending in IDLE, the grant SHALL go to the requester not granted last (round-robin); a single pending request SHALL be granted immediately.
REQ-023 ACCESS SHALL last exactly WAIT_CYCLES cycles, with BusEn=1 and the latched AddressBus/RW/Dout driven.
REQ-024 On the final ACCESS edge, Din SHALL be captured into the winner's read-data register, but only for reads.
REQ-025 RESP SHALL last one cycle: the winner's Ack=1 and BusEn=0; the next state SHALL be IDLE.
REQ-026 Latency from the grant edge to the Ack cycle SHALL be WAIT_CYCLES+1 cycles; the peak rate SHALL be one transfer per WAIT_CYCLES+2 cycles.
REQ-027 Requests SHALL be ignored during ACCESS and RESP, so a Req still high in the Ack cycle SHALL NOT cause a double grant.
REQ-028 Fetch accesses SHALL always drive RW=0 and Dout=0.
REQ-029 When BusEn=0, the arbiter SHALL drive AddressBus=0, Dout=0 and RW=0, and SHALL never drive z.
REQ-030 If a Req drops mid-ACCESS, the access SHALL still complete and the Ack SHALL still pulse.
REQ-031 FetchData/DataRdata SHALL hold their last captured value until the next read for that port.
REQ-032 The wait counter SHALL be 4 bits, load WAIT_CYCLES-1 on grant and count down to 0, with no wrap.

Reset
REQ-033 Reset=1 SHALL immediately force state=IDLE, counter=0, BusEn=0, RW=0, AddressBus=0, Dout=0, FetchAck=0, DataAck=0, FetchData=0, DataRdata=0 and Busy=0.
REQ-034 Reset SHALL set LastGrant=DATA, so the first tie goes to fetch.
REQ-035 Reset during ACCESS or RESP SHALL abort the transfer with no Ack; the requester SHALL re-request after reset.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum, the GRANT_FETCH/GRANT_DATA encoding, and the opcode constants OP_LDR=4'b1101 and OP_STR=4'b1110.
REQ-037 Sub-module rr_arb2 SHALL implement the combinational two-way round-robin decision from the requests and LastGrant.

Verification
REQ-038 Single fetch: FetchReq=1, FetchAddr=0x100, Din=0xDEADBEEF, WAIT_CYCLES=2 -> AddressBus=0x100, RW=0 and BusEn=1 for 2 cycles, then FetchAck=1 with FetchData=0xDEADBEEF in the 3rd cycle after grant.
REQ-039 Store: DataReq=1, DataRW=1, DataAddr=0x20, DataWdata=0x12345678 -> RW=1 and Dout=0x12345678 for 2 cycles, then DataAck pulses once and DataRdata is unchanged.
REQ-040 Tie after reset: both Req=1 -> fetch is served first, then data, then fetch; Acks alternate with no back-to-back grant to the same port.
REQ-041 Hold-over: the requester keeps Req=1 through the Ack cycle and drops it the next cycle -> exactly one Ack, and IDLE is reached with BusEn=0.
REQ-042 Reset mid-ACCESS: Reset is asserted on the 1st ACCESS cycle -> the same cycle shows BusEn=0, Busy=0 and no Ack; after release a new request completes normally.
REQ-043 WAIT_CYCLES=1: back-to-back data reads 0x0 then 0x4 -> Acks occur 3 cycles apart with the correct Din captured for each.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port (fetch / data) memory bus
// arbiter:
//   arb_state_t  - arbiter FSM states (IDLE, ACCESS, RESP)
//   grant_t      - encoding of which requester owns the bus
//   OP_LDR/OP_STR- opcode carried with a latched data transfer
//   op_from_rw   - maps the requester's read/write select onto an opcode
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    // Translate a 0=read / 1=write select into the transfer opcode.
    function automatic logic [3:0] op_from_rw(input logic rw);
        logic [3:0] op;
        if (rw == 1'b1) begin
            op = OP_STR;
        end else begin
            op = OP_LDR;
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin decision.
//   fetch_req  in  : fetch requester pending
//   data_req   in  : data requester pending
//   last_grant in  : requester that received the previous grant
//   gnt_valid  out : at least one request is pending
//   gnt_sel    out : winner; on a tie the requester NOT granted last wins
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   fetch_req,
    input  logic   data_req,
    input  grant_t last_grant,
    output logic   gnt_valid,
    output grant_t gnt_sel
);

    // Pick the winner; a lone request wins outright, a tie alternates.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_sel   = GRANT_FETCH;
        case ({fetch_req, data_req})
            2'b11: begin
                gnt_valid = 1'b1;
                if (last_grant == GRANT_DATA) begin
                    gnt_sel = GRANT_FETCH;
                end else begin
                    gnt_sel = GRANT_DATA;
                end
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_sel   = GRANT_FETCH;
            end
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_sel   = GRANT_DATA;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_sel   = GRANT_FETCH;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one RAM port between an instruction-fetch requester (read only) and
// a data requester (LDR/STR). Each transfer: grant edge -> WAIT_CYCLES cycles
// of ACCESS with the bus driven -> one RESP cycle with the winner's Ack.
//
// Ports
//   Clk, Reset                 clock, asynchronous active-high reset
//   FetchReq/FetchAddr         fetch request, held until FetchAck
//   FetchAck/FetchData         one-cycle completion pulse and read word
//   DataReq/DataRW/DataAddr/DataWdata  data request (RW: 0=LDR, 1=STR)
//   DataAck/DataRdata          one-cycle completion pulse and LDR word
//   AddressBus/Dout/RW/BusEn   RAM access (all zero when BusEn=0)
//   Din                        RAM read data
//   Busy                       arbiter not IDLE
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        FetchReq,
    input  logic [31:0] FetchAddr,
    output logic        FetchAck,
    output logic [31:0] FetchData,
    input  logic        DataReq,
    input  logic        DataRW,
    input  logic [31:0] DataAddr,
    input  logic [31:0] DataWdata,
    output logic        DataAck,
    output logic [31:0] DataRdata,
    output logic [31:0] AddressBus,
    output logic [31:0] Dout,
    output logic        RW,
    output logic        BusEn,
    input  logic [31:0] Din,
    output logic        Busy
);

    // Counter reload: ACCESS ends on the edge where the counter is already 0.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    arb_state_t  state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    grant_t      winner_r, winner_s;
    grant_t      last_grant_r, last_grant_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [3:0]  op_r, op_s;
    logic [31:0] fetch_data_r, fetch_data_s;
    logic [31:0] data_rdata_r, data_rdata_s;

    logic        bus_en_r, bus_en_s;
    logic [31:0] addr_bus_r, addr_bus_s;
    logic [31:0] dout_r, dout_s;
    logic        rw_r, rw_s;
    logic        fetch_ack_r, fetch_ack_s;
    logic        data_ack_r, data_ack_s;
    logic        busy_r, busy_s;

    logic        gnt_valid_s;
    grant_t      gnt_sel_s;

    rr_arb2 u_rr_arb2 (
        .fetch_req  (FetchReq),
        .data_req   (DataReq),
        .last_grant (last_grant_r),
        .gnt_valid  (gnt_valid_s),
        .gnt_sel    (gnt_sel_s)
    );

    // State and transfer-context registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            winner_r     <= GRANT_FETCH;
            last_grant_r <= GRANT_DATA;
            addr_r       <= 32'h0;
            wdata_r      <= 32'h0;
            op_r         <= OP_LDR;
            fetch_data_r <= 32'h0;
            data_rdata_r <= 32'h0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            winner_r     <= winner_s;
            last_grant_r <= last_grant_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            op_r         <= op_s;
            fetch_data_r <= fetch_data_s;
            data_rdata_r <= data_rdata_s;
        end
    end

    // Next-state logic; requests are only looked at in IDLE, which is what
    // prevents a Req still high during RESP from being granted twice.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        winner_s     = winner_r;
        last_grant_s = last_grant_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        op_s         = op_r;
        fetch_data_s = fetch_data_r;
        data_rdata_s = data_rdata_r;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    state_s      = ACCESS;
                    cnt_s        = WAIT_LOAD;
                    winner_s     = gnt_sel_s;
                    last_grant_s = gnt_sel_s;
                    if (gnt_sel_s == GRANT_FETCH) begin
                        // Fetches are reads and never drive write data.
                        addr_s  = FetchAddr;
                        wdata_s = 32'h0;
                        op_s    = OP_LDR;
                    end else begin
                        addr_s  = DataAddr;
                        op_s    = op_from_rw(DataRW);
                        if (DataRW == 1'b1) begin
                            wdata_s = DataWdata;
                        end else begin
                            wdata_s = 32'h0;
                        end
                    end
                end else begin
                    cnt_s = 4'd0;
                end
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                    // Last ACCESS edge: capture RAM data for reads only.
                    if (op_r == OP_LDR) begin
                        if (winner_r == GRANT_FETCH) begin
                            fetch_data_s = Din;
                        end else begin
                            data_rdata_s = Din;
                        end
                    end else begin
                        fetch_data_s = fetch_data_r;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Output values for the cycle after the coming edge, derived from the
    // next state so the registered outputs line up with the state register.
    always_comb begin
        bus_en_s    = 1'b0;
        addr_bus_s  = 32'h0;
        dout_s      = 32'h0;
        rw_s        = 1'b0;
        fetch_ack_s = 1'b0;
        data_ack_s  = 1'b0;
        busy_s      = 1'b0;
        if (state_s == ACCESS) begin
            bus_en_s   = 1'b1;
            addr_bus_s = addr_s;
            dout_s     = wdata_s;
            rw_s       = (op_s == OP_STR);
        end else begin
            bus_en_s   = 1'b0;
            addr_bus_s = 32'h0;
            dout_s     = 32'h0;
            rw_s       = 1'b0;
        end
        if (state_s == RESP) begin
            fetch_ack_s = (winner_s == GRANT_FETCH);
            data_ack_s  = (winner_s == GRANT_DATA);
        end else begin
            fetch_ack_s = 1'b0;
            data_ack_s  = 1'b0;
        end
        busy_s = (state_s != IDLE);
    end

    // Registered bus and handshake outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus_en_r    <= 1'b0;
            addr_bus_r  <= 32'h0;
            dout_r      <= 32'h0;
            rw_r        <= 1'b0;
            fetch_ack_r <= 1'b0;
            data_ack_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            bus_en_r    <= bus_en_s;
            addr_bus_r  <= addr_bus_s;
            dout_r      <= dout_s;
            rw_r        <= rw_s;
            fetch_ack_r <= fetch_ack_s;
            data_ack_r  <= data_ack_s;
            busy_r      <= busy_s;
        end
    end

    assign BusEn      = bus_en_r;
    assign AddressBus = addr_bus_r;
    assign Dout       = dout_r;
    assign RW         = rw_r;
    assign FetchAck   = fetch_ack_r;
    assign DataAck    = data_ack_r;
    assign Busy       = busy_r;
    assign FetchData  = fetch_data_r;
    assign DataRdata  = data_rdata_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// dut_a (WAIT_CYCLES=2) is checked every cycle against a transaction-level
// model: a transfer granted at edge g shows the bus for edges g..g+W-1,
// Acks after edge g+W and frees the arbiter for a new grant at edge g+W+2.
// dut_b (WAIT_CYCLES=1) covers back-to-back data reads.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int WA = 2;
    localparam int WB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        freq_a, dreq_a, drw_a;
    logic [31:0] faddr_a, daddr_a, dwdata_a, din_a;
    logic        fack_a, dack_a, rw_a, busen_a, busy_a;
    logic [31:0] fdata_a, drdata_a, abus_a, dout_a;

    logic        freq_b, dreq_b, drw_b;
    logic [31:0] faddr_b, daddr_b, dwdata_b, din_b;
    logic        fack_b, dack_b, rw_b, busen_b, busy_b;
    logic [31:0] fdata_b, drdata_b, abus_b, dout_b;

    // RAM behind dut_b: each word reads back as its address xor a tag.
    assign din_b = busen_b ? (abus_b ^ 32'hC0DE_0000) : 32'hFFFF_FFFF;

    mem_bus_arbiter #(.WAIT_CYCLES(WA)) dut_a (
        .Clk(clk), .Reset(rst),
        .FetchReq(freq_a), .FetchAddr(faddr_a), .FetchAck(fack_a), .FetchData(fdata_a),
        .DataReq(dreq_a), .DataRW(drw_a), .DataAddr(daddr_a), .DataWdata(dwdata_a),
        .DataAck(dack_a), .DataRdata(drdata_a),
        .AddressBus(abus_a), .Dout(dout_a), .RW(rw_a), .BusEn(busen_a),
        .Din(din_a), .Busy(busy_a)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(WB)) dut_b (
        .Clk(clk), .Reset(rst),
        .FetchReq(freq_b), .FetchAddr(faddr_b), .FetchAck(fack_b), .FetchData(fdata_b),
        .DataReq(dreq_b), .DataRW(drw_b), .DataAddr(daddr_b), .DataWdata(dwdata_b),
        .DataAck(dack_b), .DataRdata(drdata_b),
        .AddressBus(abus_b), .Dout(dout_b), .RW(rw_b), .BusEn(busen_b),
        .Din(din_b), .Busy(busy_b)
    );

    int total = 0;
    int bad   = 0;
    int k     = 0;

    // Reference model state for dut_a (m_win / m_last: 0=fetch, 1=data).
    bit          m_active;
    int          m_g;
    bit          m_win;
    bit          m_last;
    bit          m_rw;
    logic [31:0] m_addr, m_wd, m_fdata, m_drdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_g      = 0;
        m_last   = 1'b1;
        m_fdata  = 32'h0;
        m_drdata = 32'h0;
    endtask

    task automatic check_a();
        bit en;
        bit ack;
        en  = m_active && (k >= m_g) && (k <= m_g + WA - 1);
        ack = m_active && (k == m_g + WA);
        chk("busen",  busen_a, en);
        chk("addr",   abus_a, en ? m_addr : 32'h0);
        chk("rw",     rw_a, en && m_rw);
        chk("dout",   dout_a, en ? m_wd : 32'h0);
        chk("busy",   busy_a, m_active && (k <= m_g + WA));
        chk("fack",   fack_a, ack && !m_win);
        chk("dack",   dack_a, ack && m_win);
        chk("fdata",  fdata_a, m_fdata);
        chk("drdata", drdata_a, m_drdata);
    endtask

    // One clock: model the edge from the inputs it samples, check at negedge.
    task automatic tick_a();
        @(posedge clk);
        k++;
        if (rst !== 1'b1) begin
            if (!m_active || (k - 1 >= m_g + WA + 1)) begin
                if (freq_a || dreq_a) begin
                    if (freq_a && dreq_a) m_win = ~m_last;
                    else                  m_win = dreq_a;
                    m_last   = m_win;
                    m_active = 1'b1;
                    m_g      = k;
                    if (!m_win) begin
                        m_addr = faddr_a; m_rw = 1'b0; m_wd = 32'h0;
                    end else begin
                        m_addr = daddr_a; m_rw = drw_a; m_wd = drw_a ? dwdata_a : 32'h0;
                    end
                end
            end else if ((k == m_g + WA) && !m_rw) begin
                if (!m_win) m_fdata  = din_a;
                else        m_drdata = din_a;
            end
        end
        @(negedge clk);
        check_a();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        model_reset();
        tick_a();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_port[$];
        int ack_k[$];
        int acks;
        int t1;
        int t2;
        bit seen;
        bit dropflag;
        bit f_hold;
        bit d_hold;
        bit ackf;
        bit ackd;

        rst = 1'b1;
        freq_a = 1'b0; dreq_a = 1'b0; drw_a = 1'b0;
        faddr_a = 32'h0; daddr_a = 32'h0; dwdata_a = 32'h0; din_a = 32'h0;
        freq_b = 1'b0; dreq_b = 1'b0; drw_b = 1'b0;
        faddr_b = 32'h0; daddr_b = 32'h0; dwdata_b = 32'h0;
        model_reset();

        // Reset state
        tick_a();
        tick_a();
        chk("rst_busen", busen_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        rst = 1'b0;

        // Single fetch
        freq_a = 1'b1; faddr_a = 32'h100; din_a = 32'hDEADBEEF;
        tick_a();
        chk("f_c1_addr", abus_a, 32'h100);
        chk("f_c1_rw", rw_a, 1'b0);
        chk("f_c1_en", busen_a, 1'b1);
        tick_a();
        chk("f_c2_en", busen_a, 1'b1);
        tick_a();
        chk("f_ack", fack_a, 1'b1);
        chk("f_data", fdata_a, 32'hDEADBEEF);
        freq_a = 1'b0;
        tick_a();
        chk("f_ack_once", fack_a, 1'b0);

        // Store
        dreq_a = 1'b1; drw_a = 1'b1; daddr_a = 32'h20; dwdata_a = 32'h12345678;
        din_a = 32'h5555AAAA;
        tick_a();
        chk("st_c1_rw", rw_a, 1'b1);
        chk("st_c1_dout", dout_a, 32'h12345678);
        tick_a();
        chk("st_c2_dout", dout_a, 32'h12345678);
        tick_a();
        chk("st_ack", dack_a, 1'b1);
        chk("st_rdata_kept", drdata_a, 32'h0);
        dreq_a = 1'b0; drw_a = 1'b0;
        tick_a();
        chk("st_ack_once", dack_a, 1'b0);

        // Reset on the first ACCESS cycle of a data read
        dreq_a = 1'b1; daddr_a = 32'h40; din_a = 32'hCAFEF00D;
        tick_a();
        chk("rm_access", busen_a, 1'b1);
        rst = 1'b1;
        #1;
        chk("rm_busen", busen_a, 1'b0);
        chk("rm_busy", busy_a, 1'b0);
        chk("rm_noack", dack_a, 1'b0);
        model_reset();
        tick_a();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick_a();
            if (dack_a === 1'b1) seen = 1'b1;
        end
        chk("rm_recover_ack", seen, 1'b1);
        chk("rm_recover_data", drdata_a, 32'hCAFEF00D);
        dreq_a = 1'b0;
        tick_a();

        // Tie after reset: both requests stay high, grants alternate
        reset_pulse();
        freq_a = 1'b1; faddr_a = 32'h200;
        dreq_a = 1'b1; drw_a = 1'b0; daddr_a = 32'h300;
        for (int i = 0; i < 40 && ack_port.size() < 4; i++) begin
            din_a = $urandom;
            tick_a();
            if (fack_a === 1'b1) begin ack_port.push_back(0); ack_k.push_back(k); end
            if (dack_a === 1'b1) begin ack_port.push_back(1); ack_k.push_back(k); end
        end
        freq_a = 1'b0; dreq_a = 1'b0;
        chk("tie_count", ack_port.size(), 4);
        if (ack_port.size() >= 4) begin
            chk("tie_first_fetch", ack_port[0], 0);
            chk("tie_second_data", ack_port[1], 1);
            chk("tie_third_fetch", ack_port[2], 0);
            chk("tie_fourth_data", ack_port[3], 1);
            chk("tie_gap", ack_k[2] - ack_k[1], WA + 2);
        end
        tick_a();
        tick_a();

        // Hold-over: Req stays high through the Ack cycle
        freq_a = 1'b1; faddr_a = 32'h400; din_a = 32'h0BADF00D;
        acks = 0; dropflag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_a();
            if (dropflag) begin freq_a = 1'b0; dropflag = 1'b0; end
            if (fack_a === 1'b1) begin acks++; dropflag = 1'b1; end
        end
        chk("ho_one_ack", acks, 1);
        chk("ho_busen", busen_a, 1'b0);
        chk("ho_busy", busy_a, 1'b0);

        // Random traffic against the model
        f_hold = 1'b0; d_hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick_a();
            din_a = $urandom;
            ackf = m_active && (k == m_g + WA) && !m_win;
            ackd = m_active && (k == m_g + WA) && m_win;
            if (f_hold) begin
                freq_a = 1'b0; f_hold = 1'b0;
            end else if (freq_a && ackf) begin
                if ($urandom_range(0, 1) == 0) freq_a = 1'b0;
                else                           f_hold = 1'b1;
            end else if (!freq_a && $urandom_range(0, 3) == 0) begin
                freq_a = 1'b1; faddr_a = $urandom & 32'hFFFF_FFFC;
            end
            if (d_hold) begin
                dreq_a = 1'b0; d_hold = 1'b0;
            end else if (dreq_a && ackd) begin
                if ($urandom_range(0, 1) == 0) dreq_a = 1'b0;
                else                           d_hold = 1'b1;
            end else if (!dreq_a && $urandom_range(0, 3) == 0) begin
                dreq_a = 1'b1; drw_a = 1'($urandom_range(0, 1));
                daddr_a = $urandom & 32'hFFFF_FFFC; dwdata_a = $urandom;
            end
        end
        freq_a = 1'b0; dreq_a = 1'b0;
        for (int i = 0; i < 6; i++) tick_a();

        // WAIT_CYCLES=1: back-to-back data reads at 0x0 then 0x4
        dreq_b = 1'b1; drw_b = 1'b0; daddr_b = 32'h0;
        t1 = -1;
        for (int i = 0; i < 12 && t1 < 0; i++) begin
            tick_a();
            if (dack_b === 1'b1) t1 = k;
        end
        chk("b_ack0_seen", t1 >= 0, 1'b1);
        chk("b_rdata0", drdata_b, 32'hC0DE_0000);
        daddr_b = 32'h4;
        t2 = -1;
        for (int i = 0; i < 12 && t2 < 0; i++) begin
            tick_a();
            if (dack_b === 1'b1) t2 = k;
        end
        dreq_b = 1'b0;
        chk("b_ack1_seen", t2 >= 0, 1'b1);
        chk("b_gap", t2 - t1, WB + 2);
        chk("b_rdata4", drdata_b, 32'hC0DE_0004);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick_a();
            if (dack_b === 1'b1) acks++;
        end
        chk("b_no_extra_ack", acks, 0);
        chk("b_rdata_hold", drdata_b, 32'hC0DE_0004);
        chk("b_idle_busen", busen_b, 1'b0);
        chk("b_idle_busy", busy_b, 1'b0);
        chk("b_idle_addr", abus_b, 32'h0);
        chk("b_fack", fack_b, 1'b0);
        chk("b_fdata", fdata_b, 32'h0);
        chk("b_rw", rw_b, 1'b0);
        chk("b_dout", dout_b, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
